// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback over a shared ALU / memory datapath.
//
// Optional feature: define MC_MEM_WAIT_EN to add the mem_ready port and let
// FETCH, MEMREAD and MEMWRITE stall until memory completes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op, funct3          instruction opcode [6:0] and bits [14:12]
//   funct7b5            instruction bit 30 (add/sub select)
//   zero                ALU zero flag, consumed in BEQ only
//   mem_ready           memory done (MC_MEM_WAIT_EN only)
//   pc_write            PC load enable
//   adr_src             memory address: 0 PC, 1 ALU out register
//   mem_write           memory write enable
//   ir_write            IR / old-PC load enable
//   result_src          00 ALU out reg, 01 mem data reg, 10 live ALU result
//   alu_src_a           00 PC, 01 old PC, 10 rs1
//   alu_src_b           00 rs2, 01 immediate, 10 constant 4
//   alu_control         000 add, 001 sub, 010 and, 011 or, 101 slt
//   imm_src             00 I, 01 S, 10 B, 11 J
//   reg_write           register file write enable
//   instr_done          high in the last cycle of each instruction
//   illegal             high while trapped on an unknown opcode
//   state_o             current state encoding (debug)

module riscv_mc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
`ifdef MC_MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    state_t state;
    state_t state_next;
    state_t view;

    logic       mem_rdy;
    logic       pc_update;
    logic       branch;
    logic [1:0] aluop;
    logic       mw_raw;
    logic       irw_raw;
    logic       rw_raw;
    logic       done_raw;

`ifdef MC_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // ------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                state_next = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD:   state_next = S_MEMADR;
                    OP_STORE:  state_next = S_MEMADR;
                    OP_RTYPE:  state_next = S_EXECUTER;
                    OP_ITYPE:  state_next = S_EXECUTEI;
                    OP_JAL:    state_next = S_JAL;
                    OP_BRANCH: state_next = S_BEQ;
                    default:   state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                // Only lw and sw reach here; op[5] separates them.
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                state_next = mem_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                state_next = mem_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                state_next = S_ALUWB;
            end
            S_JAL: begin
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                state_next = S_FETCH;
            end
            S_BEQ: begin
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // While in reset the selects show the FETCH decode.
    assign view = rst ? S_FETCH : state;

    // ------------------------------------------------------------
    // Per-state control
    // ------------------------------------------------------------
    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        aluop      = 2'b00;
        adr_src    = 1'b0;
        mw_raw     = 1'b0;
        irw_raw    = 1'b0;
        rw_raw     = 1'b0;
        done_raw   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        case (view)
            S_FETCH: begin
                // PC+4 goes straight through to the PC.
                irw_raw    = mem_rdy;
                pc_update  = mem_rdy;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                // Branch target computed early into ALU out.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                rw_raw     = 1'b1;
                done_raw   = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src  = 1'b1;
                mw_raw   = 1'b1;
                done_raw = mem_rdy;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                aluop     = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluop     = 2'b10;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            S_ALUWB: begin
                rw_raw   = 1'b1;
                done_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                aluop     = 2'b01;
                branch    = 1'b1;
                done_raw  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            2'b01: begin
                alu_control = ALU_SUB;
            end
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        // Only R-type (op[5]=1) may subtract.
                        alu_control = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    end
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: begin
                alu_control = ALU_ADD;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Immediate format
    // ------------------------------------------------------------
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // ------------------------------------------------------------
    // Enables, gated so nothing writes during reset
    // ------------------------------------------------------------
    // funct3[0] flips the sense of zero so bne shares the beq state.
    assign pc_write   = ~rst & (pc_update | (branch & (zero ^ funct3[0])));
    assign mem_write  = ~rst & mw_raw;
    assign ir_write   = ~rst & irw_raw;
    assign reg_write  = ~rst & rw_raw;
    assign instr_done = ~rst & done_raw;
    assign illegal    = ~rst & (state == S_TRAP);
    assign state_o    = state;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller: per-cycle vector table plus
// hand sequences for trap, reset abort and (optionally) memory wait.
module tb_riscv_mc_controller;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] IA = 7'b0010011;
    localparam logic [6:0] JL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       reg_write, instr_done, illegal;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_mc_controller dut (
        .clk(clk),
        .rst(rst),
        .op(op),
        .funct3(funct3),
        .funct7b5(funct7b5),
        .zero(zero),
`ifdef MC_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .pc_write(pc_write),
        .adr_src(adr_src),
        .mem_write(mem_write),
        .ir_write(ir_write),
        .result_src(result_src),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .alu_control(alu_control),
        .imm_src(imm_src),
        .reg_write(reg_write),
        .instr_done(instr_done),
        .illegal(illegal),
        .state_o(state_o)
    );

    // Expected layout: state, pcw, adr, mw, irw, rsrc, srca, srcb,
    // aluctl, imm, rw, done, illegal
    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic [6:0] o, logic [2:0] f,
                               logic s, logic zz, logic [21:0] e);
        vec_t t;
        t.rst = r;
        t.op  = o;
        t.f3  = f;
        t.f7  = s;
        t.z   = zz;
        t.exp = e;
        return t;
    endfunction

    function automatic logic [21:0] outs();
        return {state_o, pc_write, adr_src, mem_write, ir_write,
                result_src, alu_src_a, alu_src_b, alu_control,
                imm_src, reg_write, instr_done, illegal};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic [6:0] o, logic [2:0] f,
                         logic s, logic zz);
        rst      = r;
        op       = o;
        funct3   = f;
        funct7b5 = s;
        zero     = zz;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, R, 3'b000, 1'b0, 1'b0);
        mem_ready = 1'b1;

        // reset cycle: selects as FETCH, enables off
        tbl.push_back(v(1, R, 3'b000, 0, 0, 22'b0000_0_0_0_0_10_00_10_000_00_0_0_0));
        // add
        tbl.push_back(v(0, R, 3'b000, 0, 0, 22'b0000_1_0_0_1_10_00_10_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b000, 0, 0, 22'b0001_0_0_0_0_00_01_01_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b000, 0, 0, 22'b0110_0_0_0_0_00_10_00_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b000, 0, 0, 22'b0111_0_0_0_0_00_00_00_000_00_1_1_0));
        // lw
        tbl.push_back(v(0, LW, 3'b010, 0, 0, 22'b0000_1_0_0_1_10_00_10_000_00_0_0_0));
        tbl.push_back(v(0, LW, 3'b010, 0, 0, 22'b0001_0_0_0_0_00_01_01_000_00_0_0_0));
        tbl.push_back(v(0, LW, 3'b010, 0, 0, 22'b0010_0_0_0_0_00_10_01_000_00_0_0_0));
        tbl.push_back(v(0, LW, 3'b010, 0, 0, 22'b0011_0_1_0_0_00_00_00_000_00_0_0_0));
        tbl.push_back(v(0, LW, 3'b010, 0, 0, 22'b0100_0_0_0_0_01_00_00_000_00_1_1_0));
        // sw
        tbl.push_back(v(0, SW, 3'b010, 0, 0, 22'b0000_1_0_0_1_10_00_10_000_01_0_0_0));
        tbl.push_back(v(0, SW, 3'b010, 0, 0, 22'b0001_0_0_0_0_00_01_01_000_01_0_0_0));
        tbl.push_back(v(0, SW, 3'b010, 0, 0, 22'b0010_0_0_0_0_00_10_01_000_01_0_0_0));
        tbl.push_back(v(0, SW, 3'b010, 0, 0, 22'b0101_0_1_1_0_00_00_00_000_01_0_1_0));
        // beq taken
        tbl.push_back(v(0, BR, 3'b000, 0, 1, 22'b0000_1_0_0_1_10_00_10_000_10_0_0_0));
        tbl.push_back(v(0, BR, 3'b000, 0, 1, 22'b0001_0_0_0_0_00_01_01_000_10_0_0_0));
        tbl.push_back(v(0, BR, 3'b000, 0, 1, 22'b1010_1_0_0_0_00_10_00_001_10_0_1_0));
        // beq not taken
        tbl.push_back(v(0, BR, 3'b000, 0, 0, 22'b0000_1_0_0_1_10_00_10_000_10_0_0_0));
        tbl.push_back(v(0, BR, 3'b000, 0, 0, 22'b0001_0_0_0_0_00_01_01_000_10_0_0_0));
        tbl.push_back(v(0, BR, 3'b000, 0, 0, 22'b1010_0_0_0_0_00_10_00_001_10_0_1_0));
        // bne taken
        tbl.push_back(v(0, BR, 3'b001, 0, 0, 22'b0000_1_0_0_1_10_00_10_000_10_0_0_0));
        tbl.push_back(v(0, BR, 3'b001, 0, 0, 22'b0001_0_0_0_0_00_01_01_000_10_0_0_0));
        tbl.push_back(v(0, BR, 3'b001, 0, 0, 22'b1010_1_0_0_0_00_10_00_001_10_0_1_0));
        // sub
        tbl.push_back(v(0, R, 3'b000, 1, 0, 22'b0000_1_0_0_1_10_00_10_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b000, 1, 0, 22'b0001_0_0_0_0_00_01_01_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b000, 1, 0, 22'b0110_0_0_0_0_00_10_00_001_00_0_0_0));
        tbl.push_back(v(0, R, 3'b000, 1, 0, 22'b0111_0_0_0_0_00_00_00_000_00_1_1_0));
        // slt
        tbl.push_back(v(0, R, 3'b010, 0, 0, 22'b0000_1_0_0_1_10_00_10_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b010, 0, 0, 22'b0001_0_0_0_0_00_01_01_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b010, 0, 0, 22'b0110_0_0_0_0_00_10_00_101_00_0_0_0));
        tbl.push_back(v(0, R, 3'b010, 0, 0, 22'b0111_0_0_0_0_00_00_00_000_00_1_1_0));
        // or
        tbl.push_back(v(0, R, 3'b110, 0, 0, 22'b0000_1_0_0_1_10_00_10_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b110, 0, 0, 22'b0001_0_0_0_0_00_01_01_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b110, 0, 0, 22'b0110_0_0_0_0_00_10_00_011_00_0_0_0));
        tbl.push_back(v(0, R, 3'b110, 0, 0, 22'b0111_0_0_0_0_00_00_00_000_00_1_1_0));
        // and
        tbl.push_back(v(0, R, 3'b111, 0, 0, 22'b0000_1_0_0_1_10_00_10_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b111, 0, 0, 22'b0001_0_0_0_0_00_01_01_000_00_0_0_0));
        tbl.push_back(v(0, R, 3'b111, 0, 0, 22'b0110_0_0_0_0_00_10_00_010_00_0_0_0));
        tbl.push_back(v(0, R, 3'b111, 0, 0, 22'b0111_0_0_0_0_00_00_00_000_00_1_1_0));
        // addi with funct7b5 set: still add
        tbl.push_back(v(0, IA, 3'b000, 1, 0, 22'b0000_1_0_0_1_10_00_10_000_00_0_0_0));
        tbl.push_back(v(0, IA, 3'b000, 1, 0, 22'b0001_0_0_0_0_00_01_01_000_00_0_0_0));
        tbl.push_back(v(0, IA, 3'b000, 1, 0, 22'b1000_0_0_0_0_00_10_01_000_00_0_0_0));
        tbl.push_back(v(0, IA, 3'b000, 1, 0, 22'b0111_0_0_0_0_00_00_00_000_00_1_1_0));
        // jal
        tbl.push_back(v(0, JL, 3'b000, 0, 0, 22'b0000_1_0_0_1_10_00_10_000_11_0_0_0));
        tbl.push_back(v(0, JL, 3'b000, 0, 0, 22'b0001_0_0_0_0_00_01_01_000_11_0_0_0));
        tbl.push_back(v(0, JL, 3'b000, 0, 0, 22'b1001_1_0_0_0_00_01_10_000_11_0_0_0));
        tbl.push_back(v(0, JL, 3'b000, 0, 0, 22'b0111_0_0_0_0_00_00_00_000_11_1_1_0));

        tick();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z);
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
            tick();
        end

        // illegal opcode: trap holds with all enables off
        drive(1'b0, 7'b0000000, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        chk("trap_fetch", 32'(state_o), 32'd0);
        tick();
        @(negedge clk);
        chk("trap_decode", 32'(state_o), 32'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("trap_state%0d", i), 32'(state_o), 32'd11);
            chk($sformatf("trap_ill%0d", i), 32'(illegal), 32'd1);
            chk($sformatf("trap_en%0d", i),
                32'({pc_write, mem_write, ir_write, reg_write, instr_done}),
                32'd0);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("trap_rst_ill", 32'(illegal), 32'd0);
        chk("trap_rst_en",
            32'({pc_write, mem_write, ir_write, reg_write, instr_done}), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("trap_exit", 32'(state_o), 32'd0);
        chk("trap_exit_ill", 32'(illegal), 32'd0);

        // reset during MEMWRITE aborts the store
        drive(1'b0, SW, 3'b010, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("abort_pre_state", 32'(state_o), 32'd5);
        chk("abort_pre_mw", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_mw", 32'(mem_write), 32'd0);
        chk("abort_done", 32'(instr_done), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_next", 32'(state_o), 32'd0);

`ifdef MC_MEM_WAIT_EN
        // fetch stalls for three cycles, loads IR on the fourth
        mem_ready = 1'b0;
        drive(1'b0, R, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("wait_state%0d", i), 32'(state_o), 32'd0);
            chk($sformatf("wait_irw%0d", i), 32'(ir_write), 32'd0);
            chk($sformatf("wait_pcw%0d", i), 32'(pc_write), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("wait_go_state", 32'(state_o), 32'd0);
        chk("wait_go_irw", 32'(ir_write), 32'd1);
        tick();
        @(negedge clk);
        chk("wait_decode", 32'(state_o), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
